// File: rtl/uart_pkg.sv
// Shared UART definitions: parity selection constants, transmit FSM states
// and the frame length helper used by the transmitter (and future receiver).
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  typedef enum logic {
    IDLE,
    SHIFT
  } tx_state_t;

  // Start bit + data bits + optional parity bit + stop bits.
  function automatic int frame_w(input int data_w, input logic [1:0] parity,
                                 input int stop_bits);
    return 1 + data_w + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud divider: counts 0..BAUD_DIV-1 and flags the terminal count.
// A clear restarts the bit period from zero.
module uart_baud_tick #(
  parameter int BAUD_DIV = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: one-word holding register behind a valid/ready
// handshake, feeding an LSB-first shift register with parity and stop bits.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int         DATA_W    = 8,
  parameter logic [1:0] PARITY    = PAR_NONE,
  parameter int         STOP_BITS = 1,
  parameter int         BAUD_DIV  = 434
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              txd,
  output logic              busy,
  output logic              done
);

  localparam int FRAME_W = frame_w(DATA_W, PARITY, STOP_BITS);
  localparam int BIT_CW  = $clog2(FRAME_W + 1);
  localparam logic [BIT_CW-1:0] LAST_BIT = BIT_CW'(FRAME_W - 1);

  tx_state_t          state, next_state;
  logic [DATA_W-1:0]  hold_data;
  logic               hold_full;
  logic [FRAME_W-1:0] shreg;
  logic [FRAME_W-1:0] frame_vec;
  logic [BIT_CW-1:0]  bit_cnt;
  logic               par_bit;
  logic               accept;
  logic               load;
  logic               shift;
  logic               baud_clr;
  logic               tick;

  assign tx_ready = !hold_full;
  assign accept   = tx_valid && !hold_full;
  assign baud_clr = (state == IDLE) || load;
  assign txd      = shreg[0];

  uart_baud_tick #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (baud_clr),
    .tick(tick)
  );

  // Frame image: stop ones above the optional parity bit, data, start zero.
  always_comb begin
    par_bit = (^hold_data) ^ (PARITY == PAR_ODD);
    frame_vec = '1;
    frame_vec[0] = 1'b0;
    frame_vec[DATA_W:1] = hold_data;
    if (PARITY != PAR_NONE) begin
      frame_vec[DATA_W+1] = par_bit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_data <= '0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_data <= tx_data;
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  // Ones shift in from the top, so the line rests high once a frame drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '1;
      bit_cnt <= '0;
    end else if (load) begin
      shreg   <= frame_vec;
      bit_cnt <= '0;
    end else if (shift) begin
      shreg   <= {1'b1, shreg[FRAME_W-1:1]};
      bit_cnt <= bit_cnt + BIT_CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A waiting word reloads on the final tick so frames run back to back.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    shift      = 1'b0;
    done       = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          load       = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (tick) begin
          if (bit_cnt == LAST_BIT) begin
            done = 1'b1;
            if (hold_full) begin
              load = 1'b1;
            end else begin
              shift      = 1'b1;
              next_state = IDLE;
            end
          end else begin
            shift = 1'b1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: four configurations side by side, each
// frame checked cycle by cycle against hand-computed line images.
module tb_uart_tx_frame;
  import uart_pkg::*;

  logic       clk;
  logic       rst;
  logic [8:0] tx_data  [4];
  logic       tx_valid [4];
  logic       tx_ready [4];
  logic       txd      [4];
  logic       busy     [4];
  logic       done     [4];

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_W(8), .PARITY(PAR_EVEN), .STOP_BITS(1), .BAUD_DIV(4)) u_even (
    .clk(clk), .rst(rst), .tx_data(tx_data[0][7:0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .txd(txd[0]), .busy(busy[0]), .done(done[0]));

  uart_tx_frame #(.DATA_W(8), .PARITY(PAR_ODD), .STOP_BITS(1), .BAUD_DIV(4)) u_odd (
    .clk(clk), .rst(rst), .tx_data(tx_data[1][7:0]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .txd(txd[1]), .busy(busy[1]), .done(done[1]));

  uart_tx_frame #(.DATA_W(7), .PARITY(PAR_NONE), .STOP_BITS(2), .BAUD_DIV(3)) u_seven (
    .clk(clk), .rst(rst), .tx_data(tx_data[2][6:0]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .txd(txd[2]), .busy(busy[2]), .done(done[2]));

  uart_tx_frame #(.DATA_W(8), .PARITY(PAR_NONE), .STOP_BITS(1), .BAUD_DIV(4)) u_plain (
    .clk(clk), .rst(rst), .tx_data(tx_data[3][7:0]), .tx_valid(tx_valid[3]),
    .tx_ready(tx_ready[3]), .txd(txd[3]), .busy(busy[3]), .done(done[3]));

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Send one word on instance d and follow the line for the whole frame.
  task automatic apply_stimulus(input int d, input logic [8:0] data, input logic [12:0] bits,
                                input int nbits, input int div, input string tag);
    int   fcyc;
    logic exp_txd;
    fcyc = nbits * div;
    @(negedge clk);
    check_output({tag, "_rdy_init"}, 32'(tx_ready[d]), 32'd1);
    tx_valid[d] = 1'b1;
    tx_data[d]  = data;
    @(posedge clk);
    #1 tx_valid[d] = 1'b0;
    for (int c = 0; c <= fcyc + 1; c++) begin
      @(negedge clk);
      exp_txd = (c >= 1 && c <= fcyc) ? bits[(c - 1) / div] : 1'b1;
      check_output($sformatf("%s_txd_c%0d", tag, c), 32'(txd[d]), 32'(exp_txd));
      check_output($sformatf("%s_busy_c%0d", tag, c), 32'(busy[d]), 32'(c >= 1 && c <= fcyc));
      check_output($sformatf("%s_done_c%0d", tag, c), 32'(done[d]), 32'(c == fcyc));
      check_output($sformatf("%s_rdy_c%0d", tag, c), 32'(tx_ready[d]), 32'(c >= 1));
    end
  endtask

  // Three words with tx_valid held high on the 8/none/1/4 instance.
  task automatic run_back_to_back();
    logic [8:0]  words  [3];
    logic [12:0] frames [3];
    int          idx;
    logic        will_accept;
    logic        exp_txd;
    words  = '{9'h12, 9'h34, 9'h5A};
    frames = '{13'h224, 13'h268, 13'h2B4};
    @(negedge clk);
    check_output("b2b_rdy_init", 32'(tx_ready[3]), 32'd1);
    tx_valid[3] = 1'b1;
    tx_data[3]  = words[0];
    @(posedge clk);
    #1;
    idx = 1;
    tx_data[3] = words[1];
    for (int c = 0; c <= 121; c++) begin
      @(negedge clk);
      exp_txd = (c >= 1 && c <= 120) ? frames[(c - 1) / 40][((c - 1) % 40) / 4] : 1'b1;
      check_output($sformatf("b2b_txd_c%0d", c), 32'(txd[3]), 32'(exp_txd));
      check_output($sformatf("b2b_busy_c%0d", c), 32'(busy[3]), 32'(c >= 1 && c <= 120));
      check_output($sformatf("b2b_done_c%0d", c), 32'(done[3]),
                   32'(c == 40 || c == 80 || c == 120));
      check_output($sformatf("b2b_rdy_c%0d", c), 32'(tx_ready[3]),
                   32'(c == 1 || c == 41 || c >= 81));
      will_accept = tx_valid[3] && tx_ready[3];
      @(posedge clk);
      #1;
      if (will_accept) begin
        idx++;
        if (idx < 3) tx_data[3] = words[idx];
        else tx_valid[3] = 1'b0;
      end
    end
  endtask

  // Reset in the middle of data bit 3 with a second word already buffered.
  task automatic run_reset_mid_frame();
    @(negedge clk);
    tx_valid[0] = 1'b1;
    tx_data[0]  = 9'hA5;
    @(posedge clk);
    #1 tx_data[0] = 9'h3C;
    @(posedge clk);
    @(posedge clk);
    #1 tx_valid[0] = 1'b0;
    repeat (17) @(negedge clk);
    check_output("rst_pre_txd", 32'(txd[0]), 32'd0);
    check_output("rst_pre_busy", 32'(busy[0]), 32'd1);
    check_output("rst_pre_rdy", 32'(tx_ready[0]), 32'd0);
    rst = 1'b1;
    #1;
    check_output("rst_txd", 32'(txd[0]), 32'd1);
    check_output("rst_rdy", 32'(tx_ready[0]), 32'd1);
    check_output("rst_busy", 32'(busy[0]), 32'd0);
    check_output("rst_done", 32'(done[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_output("rst_after_busy", 32'(busy[0]), 32'd0);
    check_output("rst_after_txd", 32'(txd[0]), 32'd1);
    check_output("rst_after_rdy", 32'(tx_ready[0]), 32'd1);
    apply_stimulus(0, 9'h3C, 13'h478, 11, 4, "post_rst");
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      tx_valid[i] = 1'b0;
      tx_data[i]  = '0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("reset_txd%0d", i), 32'(txd[i]), 32'd1);
      check_output($sformatf("reset_rdy%0d", i), 32'(tx_ready[i]), 32'd1);
      check_output($sformatf("reset_busy%0d", i), 32'(busy[i]), 32'd0);
      check_output($sformatf("reset_done%0d", i), 32'(done[i]), 32'd0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    apply_stimulus(0, 9'hA5, 13'h54A, 11, 4, "even_a5");
    apply_stimulus(1, 9'h00, 13'h600, 11, 4, "odd_00");
    apply_stimulus(1, 9'hFF, 13'h7FE, 11, 4, "odd_ff");
    apply_stimulus(2, 9'h55, 13'h3AA, 10, 3, "seven_55");
    run_back_to_back();
    run_reset_mid_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmit framer. It accepts parallel words over a valid/ready handshake and buffers one word while the previous frame is on the line. Each word is serialised LSB-first as start, data, optional parity and 1–2 stop bits, with bit timing from an internal baud divider. It sits between the bus-side register interface and the `txd` pin, and is the generalised successor of the fixed 11-bit load/shift transmit register.

## Interface
- `DATA_W`, 8: data bits per frame, legal 5..9.
- `PARITY`, `PAR_NONE`: `PAR_NONE` / `PAR_EVEN` / `PAR_ODD` (constants from `uart_pkg`).
- `STOP_BITS`, 1: stop bits per frame, legal 1 or 2.
- `BAUD_DIV`, 434: clk cycles per bit, legal >= 2.

- `clk`  in  1  clock; reset `rst`, asynchronous, active-high.
- `rst`  in  1  asynchronous, active-high reset.
- `tx_data`  in  `DATA_W`  word to send; sampled on accept.
- `tx_valid`  in  1  producer has a word.
- `tx_ready`  out  1  holding register empty; reset 1.
- `txd`  out  1  serial line, registered, idle high; reset 1.
- `busy`  out  1  frame in progress; reset 0.
- `done`  out  1  one-cycle pulse at end of each frame; reset 0.

## Operation
- Frame length: `FRAME_W = 1 + DATA_W + (PARITY != PAR_NONE) + STOP_BITS`, range 7..13.
- Accept: on a clk edge with `tx_valid && tx_ready`, `tx_data` is captured into the holding register and `hold_full` is set. `tx_ready = !hold_full`; there is no same-cycle bypass.
- Parity: even parity bit = XOR of data bits; odd parity bit = its inverse. Parity is computed from the holding register at load.
- Shift register, `FRAME_W` bits, loaded as {stop ones, parity, data, 1'b0}. It shifts right with 1 filled in at the MSB. `txd` is driven from bit 0.
- FSM, two states:
  - `IDLE`: `txd`=1, `busy`=0. If `hold_full`: load the shift register, clear `hold_full`, clear the baud and bit counters, go to `SHIFT`.
  - `SHIFT`: `busy`=1. The baud counter counts 0..`BAUD_DIV`-1. On its terminal count the register shifts and the bit counter increments.
  - Last terminal count of bit `FRAME_W`-1: pulse `done`. If `hold_full`, reload directly and stay in `SHIFT` with no idle gap; otherwise go to `IDLE`.
- Producer must hold `tx_data` stable while `tx_valid && !tx_ready`. The block never drops or duplicates an accepted word.
- `rst` at any time, including mid-frame: line returns to 1 immediately, the frame is abandoned, the holding word is discarded, FSM goes to `IDLE`, counters clear.

## Timing
- Accept at edge N into an idle block: load at edge N+1. The start bit is on `txd` from N+1 for exactly `BAUD_DIV` cycles.
- `tx_ready` falls after edge N and rises again after load edge N+1. A second word can be accepted at N+2, during the first frame.
- Bit k occupies `txd` for cycles [N+1+k·`BAUD_DIV`, N+1+(k+1)·`BAUD_DIV`).
- `done` is high in the final clk cycle of the last stop bit, i.e. cycle N+`FRAME_W`·`BAUD_DIV`.
- Back-to-back: the next start bit begins the cycle after `done`. Line high time between frames is exactly `STOP_BITS`·`BAUD_DIV`.
- Widths: baud counter `$clog2(BAUD_DIV)`, bit counter `$clog2(FRAME_W+1)`. No counter wraps outside the stated ranges.

## Structure
- Package `uart_pkg` holds:
  - parity constants `PAR_NONE`=0, `PAR_EVEN`=1, `PAR_ODD`=2 (2-bit);
  - FSM state typedef;
  - function `frame_w(data_w, parity, stop_bits)`.
- Sub-module `uart_baud_tick`: clear input plus terminal-count tick output, parametrised by `BAUD_DIV`. It is shared with the future receiver.
- Top holds the handshake, holding register, parity, shift register, bit counter and FSM.

## Test plan
- Config 8/`PAR_EVEN`/1/4, send 0xA5 -> `txd` = 0,1,0,1,0,0,1,0,1,0,1, each bit held 4 cycles. `done` at accept+44. `busy` falls after.
- Config 8/`PAR_ODD`/1/4, send 0x00 -> parity bit 1. Send 0xFF -> parity bit 1.
- Config 7/`PAR_NONE`/2/3, send 0x55 -> 10-bit frame 0,1,0,1,0,1,0,1,1,1, 30 cycles.
- `tx_valid` held high with 0x12 then 0x34 -> second accepted at accept+2. Second start bit immediately follows the first frame's stop bit with no idle. Two `done` pulses 40 cycles apart (8/none/1/4).
- Backpressure: third word presented while the holding register is full -> `tx_ready`=0 and no accept until the second frame loads. All three words appear in order.
- Assert `rst` during data bit 3 -> `txd`=1, `tx_ready`=1, `busy`=0, `done`=0 immediately. A fresh send after release produces a full, correct frame.
